// File: rtl/seg7_pkg.sv
// Shared definitions for the scanned 7-segment display drivers: the
// active-low hex glyph table, the blank pattern and the glyph lookup.
package seg7_pkg;

    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // Index = nybble value; bits are {g,f,e,d,c,b,a}, 0 = segment lit.
    localparam logic [6:0] GLYPH [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30,
        7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03,
        7'h46, 7'h21, 7'h06, 7'h0E
    };

    function automatic logic [6:0] hex2seg(input logic [3:0] nybble);
        return GLYPH[nybble];
    endfunction

endpackage

// File: rtl/seg7_tick_gen.sv
// Free-running prescaler: TICK is high on the last cycle of every DIV-cycle
// period. DIV = 1 keeps TICK permanently high.
module seg7_tick_gen #(
    parameter int DIV = 1024
) (
    input  logic CLK,
    input  logic RST,
    output logic TICK
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign TICK = (cnt == LAST);

endmodule

// File: rtl/seg7_scan_mux.sv
// N-digit multiplexed 7-segment driver with PWM brightness, guard time and
// frame-coherent snapshot. Define SEG7_LZ_BLANK_EN for leading-zero blanking.
module seg7_scan_mux
    import seg7_pkg::*;
#(
    parameter int NDIG  = 4,
    parameter int DIV   = 1024,
    parameter int BW    = 4,
    parameter int GUARD = 1
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [4*NDIG-1:0]   HEX_IN,
    input  logic [NDIG-1:0]     DP_IN,
    input  logic [NDIG-1:0]     DIGIT_EN,
    input  logic [BW-1:0]       BRIGHT,
    output logic [7:0]          SEG_OUT,
    output logic [NDIG-1:0]     DIGIT_OUT,
    output logic                FRAME_TICK
);

    localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [BW-1:0] PHASE_LAST = '1;
    localparam logic [IW-1:0] IDX_LAST   = IW'(NDIG - 1);

    logic                tick;
    logic [BW-1:0]       phase;
    logic [IW-1:0]       idx;
    logic                slot_end;
    logic                frame_end;

    logic [4*NDIG-1:0]   hex_snap;
    logic [NDIG-1:0]     dp_snap;
    logic [NDIG-1:0]     en_snap;
    logic [NDIG-1:0]     lz_sup;

    logic [3:0]          cur_nyb;
    logic                cur_dp;
    logic                cur_en;
    logic                cur_sup;
    logic                guard_ok;
    logic                bright_ok;
    logic                lit;

    logic [7:0]          seg_nxt;
    logic [NDIG-1:0]     dig_nxt;

    seg7_tick_gen #(
        .DIV (DIV)
    ) u_tick_gen (
        .CLK  (CLK),
        .RST  (RST),
        .TICK (tick)
    );

    assign slot_end  = tick && (phase == PHASE_LAST);
    assign frame_end = slot_end && (idx == IDX_LAST);

    // Phase runs through the slot; the digit index steps once per slot and
    // wraps explicitly so non-power-of-two digit counts scan correctly.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            phase <= '0;
            idx   <= '0;
        end else if (tick) begin
            phase <= phase + 1'b1;
            if (slot_end) begin
                idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            hex_snap <= '0;
            dp_snap  <= '0;
            en_snap  <= '0;
        end else if (frame_end) begin
            hex_snap <= HEX_IN;
            dp_snap  <= DP_IN;
            en_snap  <= DIGIT_EN;
        end
    end

`ifdef SEG7_LZ_BLANK_EN
    // A zero digit is dropped while everything above it is dark; a set DP
    // keeps the digit (and so everything below it) visible.
    logic higher_blank;

    always_comb begin
        lz_sup       = '0;
        higher_blank = 1'b1;
        for (int k = NDIG - 1; k >= 0; k--) begin
            if (k != 0 && higher_blank && hex_snap[4*k +: 4] == 4'h0 && !dp_snap[k]) begin
                lz_sup[k] = 1'b1;
            end
            higher_blank = higher_blank && (!en_snap[k] || lz_sup[k]);
        end
    end
`else
    assign lz_sup = '0;
`endif

    always_comb begin
        cur_nyb = 4'h0;
        cur_dp  = 1'b0;
        cur_en  = 1'b0;
        cur_sup = 1'b0;
        for (int k = 0; k < NDIG; k++) begin
            if (idx == IW'(k)) begin
                cur_nyb = hex_snap[4*k +: 4];
                cur_dp  = dp_snap[k];
                cur_en  = en_snap[k];
                cur_sup = lz_sup[k];
            end
        end
    end

    generate
        if (GUARD == 0) begin : g_no_guard
            assign guard_ok = 1'b1;
        end else begin : g_guard
            assign guard_ok = (phase >= BW'(GUARD));
        end
    endgenerate

    // BRIGHT is used live so brightness changes need not wait for a frame.
    assign bright_ok = (phase < BRIGHT);
    assign lit       = cur_en && !cur_sup && guard_ok && bright_ok;

    always_comb begin
        seg_nxt = SEG_BLANK;
        dig_nxt = '1;
        if (lit) begin
            seg_nxt = {~cur_dp, hex2seg(cur_nyb)};
            for (int k = 0; k < NDIG; k++) begin
                dig_nxt[k] = (idx != IW'(k));
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            SEG_OUT    <= SEG_BLANK;
            DIGIT_OUT  <= '1;
            FRAME_TICK <= 1'b0;
        end else begin
            SEG_OUT    <= seg_nxt;
            DIGIT_OUT  <= dig_nxt;
            FRAME_TICK <= frame_end;
        end
    end

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Bench for seg7_scan_mux: two instances (4 digits / DIV 4 and 3 digits /
// DIV 1) checked every cycle against a frame-arithmetic reference model.
module tb_seg7_scan_mux;

  localparam int GUARD_T = 1;
  localparam int FRAME_A = 4 * 8 * 4;
  localparam int FRAME_B = 1 * 8 * 3;

  // Active-high {g..a} glyphs; the model inverts them for the pins.
  localparam logic [6:0] GLYPH_ON [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  logic clk = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;

  logic [15:0] hex_a = '0;
  logic [3:0]  dp_a = '0;
  logic [3:0]  en_a = '0;
  logic [2:0]  bright_a = '0;
  logic [7:0]  seg_a;
  logic [3:0]  dig_a;
  logic        ft_a;

  logic [11:0] hex_b = '0;
  logic [2:0]  dp_b = '0;
  logic [2:0]  en_b = '0;
  logic [2:0]  bright_b = '0;
  logic [7:0]  seg_b;
  logic [2:0]  dig_b;
  logic        ft_b;

  int errors = 0;
  int checks = 0;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  seg7_scan_mux #(.NDIG(4), .DIV(4), .BW(3), .GUARD(GUARD_T)) dut_a (
    .CLK(clk), .RST(rst_a), .HEX_IN(hex_a), .DP_IN(dp_a), .DIGIT_EN(en_a),
    .BRIGHT(bright_a), .SEG_OUT(seg_a), .DIGIT_OUT(dig_a), .FRAME_TICK(ft_a)
  );

  seg7_scan_mux #(.NDIG(3), .DIV(1), .BW(3), .GUARD(GUARD_T)) dut_b (
    .CLK(clk), .RST(rst_b), .HEX_IN(hex_b), .DP_IN(dp_b), .DIGIT_EN(en_b),
    .BRIGHT(bright_b), .SEG_OUT(seg_b), .DIGIT_OUT(dig_b), .FRAME_TICK(ft_b)
  );

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Expected {seg, digit_n} for the counter state reached after s clock edges,
  // given the frame snapshot in force and the live brightness.
  function automatic logic [23:0] model_out(input int s, input int ndig, input int div,
                                            input logic [63:0] hex, input logic [15:0] dp,
                                            input logic [15:0] en, input logic [2:0] bright);
    int ticks, p, d;
    logic [3:0] nyb;
    logic sup;
    logic [7:0] seg;
    logic [15:0] dig;
    ticks = s / div;
    p = ticks % 8;
    d = (ticks / 8) % ndig;
    nyb = hex[4*d +: 4];
    sup = 1'b0;
`ifdef SEG7_LZ_BLANK_EN
    if (d != 0) begin
      sup = 1'b1;
      for (int k = d; k < ndig; k++) begin
        if (k == d) begin
          if (!(hex[4*k +: 4] == 4'h0 && !dp[k])) sup = 1'b0;
        end else begin
          if (!(!en[k] || (hex[4*k +: 4] == 4'h0 && !dp[k]))) sup = 1'b0;
        end
      end
    end
`endif
    seg = 8'hFF;
    dig = 16'hFFFF;
    if (en[d] && !sup && p >= GUARD_T && p < int'(bright)) begin
      seg = {~dp[d], ~GLYPH_ON[nyb]};
      dig[d] = 1'b0;
    end
    return {seg, dig};
  endfunction

  // ---------------- scoreboard state: edge counts and frame snapshots ----------------
  int          e_a, e_b;
  logic [15:0] sh_a, sh_a_used;
  logic [3:0]  sd_a, sd_a_used, se_a, se_a_used;
  logic [2:0]  br_a_used;
  logic [11:0] sh_b, sh_b_used;
  logic [2:0]  sd_b, sd_b_used, se_b, se_b_used;
  logic [2:0]  br_b_used;
  logic [23:0] m_a, m_b;
  logic [12:0] exp_a;
  logic [11:0] exp_b;

  always @(posedge clk or posedge rst_a) begin
    if (rst_a) begin
      e_a <= 0;
      sh_a <= '0; sd_a <= '0; se_a <= '0;
      sh_a_used <= '0; sd_a_used <= '0; se_a_used <= '0; br_a_used <= '0;
    end else begin
      e_a <= e_a + 1;
      sh_a_used <= sh_a; sd_a_used <= sd_a; se_a_used <= se_a; br_a_used <= bright_a;
      if ((e_a + 1) % FRAME_A == 0) begin
        sh_a <= hex_a; sd_a <= dp_a; se_a <= en_a;
      end
    end
  end

  always @(posedge clk or posedge rst_b) begin
    if (rst_b) begin
      e_b <= 0;
      sh_b <= '0; sd_b <= '0; se_b <= '0;
      sh_b_used <= '0; sd_b_used <= '0; se_b_used <= '0; br_b_used <= '0;
    end else begin
      e_b <= e_b + 1;
      sh_b_used <= sh_b; sd_b_used <= sd_b; se_b_used <= se_b; br_b_used <= bright_b;
      if ((e_b + 1) % FRAME_B == 0) begin
        sh_b <= hex_b; sd_b <= dp_b; se_b <= en_b;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_a || e_a == 0) begin
      exp_a = {1'b0, 8'hFF, 4'hF};
    end else begin
      m_a = model_out(e_a - 1, 4, 4, 64'(sh_a_used), 16'(sd_a_used), 16'(se_a_used), br_a_used);
      exp_a = {(e_a % FRAME_A == 0), m_a[23:16], m_a[3:0]};
    end
    check_eq("cycle_a", 32'({ft_a, seg_a, dig_a}), 32'(exp_a));
  end

  always @(negedge clk) begin
    if (rst_b || e_b == 0) begin
      exp_b = {1'b0, 8'hFF, 3'h7};
    end else begin
      m_b = model_out(e_b - 1, 3, 1, 64'(sh_b_used), 16'(sd_b_used), 16'(se_b_used), br_b_used);
      exp_b = {(e_b % FRAME_B == 0), m_b[23:16], m_b[2:0]};
    end
    check_eq("cycle_b", 32'({ft_b, seg_b, dig_b}), 32'(exp_b));
  end

  // ---------------- driver tasks ----------------
  int          lit_a [4];
  logic [7:0]  seen_a [4];

  task automatic wait_ft_a();
    int found = 0;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (ft_a) begin
        found = 1;
        break;
      end
    end
    check_eq("ft_a_seen", 32'(found), 32'd1);
  endtask

  task automatic run_a(input int n);
    for (int d = 0; d < 4; d++) begin
      lit_a[d] = 0;
      seen_a[d] = 8'hFF;
    end
    repeat (n) begin
      @(negedge clk);
      for (int d = 0; d < 4; d++) begin
        if (!dig_a[d]) begin
          lit_a[d]++;
          seen_a[d] = seg_a;
        end
      end
    end
  endtask

  task automatic check_lit_a(input string tag, input int l3, input int l2, input int l1, input int l0);
    check_eq({tag, "_d0"}, 32'(lit_a[0]), 32'(l0));
    check_eq({tag, "_d1"}, 32'(lit_a[1]), 32'(l1));
    check_eq({tag, "_d2"}, 32'(lit_a[2]), 32'(l2));
    check_eq({tag, "_d3"}, 32'(lit_a[3]), 32'(l3));
  endtask

  task automatic ft_gap_b(input string tag, input int exp_gap);
    int gap = 0;
    for (int n = 1; n <= 100; n++) begin
      @(negedge clk);
      if (ft_b) begin
        gap = n;
        break;
      end
    end
    check_eq(tag, 32'(gap), 32'(exp_gap));
  endtask

  task automatic seq_a();
    repeat (3) @(negedge clk);
    check_eq("rst_seg_a", 32'(seg_a), 32'hFF);
    check_eq("rst_dig_a", 32'(dig_a), 32'hF);
    check_eq("rst_ft_a", 32'(ft_a), 32'h0);
    hex_a = 16'h12AF; en_a = 4'hF; dp_a = 4'h0; bright_a = 3'd7;
    rst_a = 1'b0;
    wait_ft_a();
    run_a(FRAME_A);
    check_lit_a("br7", 24, 24, 24, 24);
    check_eq("glyph_F", 32'(seen_a[0]), 32'h8E);
    check_eq("glyph_A", 32'(seen_a[1]), 32'h88);
    check_eq("glyph_2", 32'(seen_a[2]), 32'hA4);
    check_eq("glyph_1", 32'(seen_a[3]), 32'hF9);
    // mid-frame change must wait for the next frame
    wait_ft_a();
    run_a(FRAME_A / 2);
    hex_a = 16'h0000;
    run_a(FRAME_A / 2);
    check_eq("mid_old_d2", 32'(seen_a[2]), 32'hA4);
    check_eq("mid_old_d3", 32'(seen_a[3]), 32'hF9);
    run_a(FRAME_A);
    check_eq("mid_new_d3", 32'(seen_a[3]), 32'hC0);
    // brightness windows
    wait_ft_a();
    bright_a = 3'd1;
    run_a(FRAME_A);
    check_lit_a("br1", 0, 0, 0, 0);
    bright_a = 3'd3;
    run_a(FRAME_A);
    check_lit_a("br3", 8, 8, 8, 8);
    // per-digit enable and decimal point
    hex_a = 16'h12AF; en_a = 4'b0101; dp_a = 4'b0001; bright_a = 3'd7;
    wait_ft_a();
    run_a(FRAME_A);
    check_lit_a("en0101", 0, 24, 0, 24);
    check_eq("dp_d0", 32'(seen_a[0]), 32'h0E);
    // random traffic, scored cycle by cycle
    repeat (8 * FRAME_A) begin
      @(negedge clk);
      if ($urandom_range(0, 15) == 0) hex_a = 16'($urandom);
      if ($urandom_range(0, 31) == 0) dp_a = 4'($urandom);
      if ($urandom_range(0, 31) == 0) en_a = 4'($urandom);
      if ($urandom_range(0, 40) == 0) bright_a = 3'($urandom_range(0, 7));
    end
    // zero handling
    hex_a = 16'h0050; en_a = 4'hF; dp_a = 4'h0; bright_a = 3'd7;
    wait_ft_a();
    run_a(FRAME_A);
`ifdef SEG7_LZ_BLANK_EN
    check_lit_a("lz0050", 0, 0, 24, 24);
`else
    check_lit_a("lz0050", 24, 24, 24, 24);
`endif
    check_eq("lz0050_d1", 32'(seen_a[1]), 32'h92);
    check_eq("lz0050_d0", 32'(seen_a[0]), 32'hC0);
    hex_a = 16'h0000;
    wait_ft_a();
    run_a(FRAME_A);
`ifdef SEG7_LZ_BLANK_EN
    check_lit_a("lz0000", 0, 0, 0, 24);
`else
    check_lit_a("lz0000", 24, 24, 24, 24);
`endif
    check_eq("lz0000_d0", 32'(seen_a[0]), 32'hC0);
  endtask

  task automatic seq_b();
    logic [2:0] seq_q[$];
    logic [2:0] prev;
    int lit_found;
    hex_b = 12'($urandom); en_b = 3'h7; dp_b = 3'h0; bright_b = 3'd7;
    repeat (4) @(negedge clk);
    rst_b = 1'b0;
    ft_gap_b("ft_first_b", FRAME_B);
    ft_gap_b("ft_period_b", FRAME_B);
    repeat (10 * FRAME_B) begin
      @(negedge clk);
      if ($urandom_range(0, 7) == 0) hex_b = 12'($urandom);
      if ($urandom_range(0, 15) == 0) dp_b = 3'($urandom);
      if ($urandom_range(0, 15) == 0) en_b = 3'($urandom);
      if ($urandom_range(0, 20) == 0) bright_b = 3'($urandom_range(0, 7));
    end
    en_b = 3'h7; bright_b = 3'd7;
    // async reset while a digit is lit
    lit_found = 0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (dig_b != 3'b111) begin
        lit_found = 1;
        break;
      end
    end
    check_eq("b_lit_before_rst", 32'(lit_found), 32'd1);
    #2 rst_b = 1'b1;
    #1;
    check_eq("async_dig_b", 32'(dig_b), 32'h7);
    check_eq("async_seg_b", 32'(seg_b), 32'hFF);
    check_eq("async_ft_b", 32'(ft_b), 32'h0);
    repeat (2) @(negedge clk);
    rst_b = 1'b0;
    ft_gap_b("ft_after_rst_b", FRAME_B);
    lit_found = 0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (dig_b != 3'b111) begin
        lit_found = 1;
        break;
      end
    end
    check_eq("restart_dig0_b", 32'(dig_b), 32'h6);
    prev = 3'b110;
    repeat (2 * FRAME_B) begin
      @(negedge clk);
      if (dig_b != 3'b111 && dig_b != prev) begin
        seq_q.push_back(dig_b);
        prev = dig_b;
      end
    end
    check_eq("idx_seq_1", 32'(seq_q.size() > 0 ? seq_q[0] : 3'b000), 32'h5);
    check_eq("idx_seq_2", 32'(seq_q.size() > 1 ? seq_q[1] : 3'b000), 32'h3);
    check_eq("idx_seq_0", 32'(seq_q.size() > 2 ? seq_q[2] : 3'b000), 32'h6);
  endtask

  // ---------------- main + report ----------------
  initial begin
    fork
      seq_a();
      seq_b();
    join
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule
